serial_mult: RTL and testbench



---
 rtl/serial_mult.sv | 150 +++++++++++++++
 tb/tb_serial_mult.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/serial_mult.sv
// Serial-input shift-add multiplier: length field, A, B streamed LSB first.
// Define MULT_SIGNED_EN for two's complement operands (default: unsigned).
module serial_mult #(
  parameter int LEN_W  = 8,
  parameter int MAX_W  = 16,
  parameter int PROD_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in,
  input  logic            ctrl,
  output logic [PROD_W:0] prod
);

  localparam int CW = $clog2(MAX_W + 1);

  typedef enum logic [2:0] {
    IDLE, RX_LEN, RX_A, RX_B, CALC, FIN, DONE
  } state_t;

  state_t              state_q, state_d;
  logic                ctrl_q;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [CW-1:0]       n_q, n_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [PROD_W-1:0]   a_q, a_d;
  logic [MAX_W-1:0]    b_q, b_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic [PROD_W:0]     prod_q, prod_d;

  logic                start;
  logic                last;
  logic [LEN_W-1:0]    len_full;

  assign start    = ctrl & ~ctrl_q;
  assign last     = (cnt_q == n_q - CW'(1));
  assign len_full = {in, len_q[LEN_W-1:1]};
  assign prod     = prod_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ctrl_q  <= 1'b0;
      len_q   <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl;
      len_q   <= len_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    prod_d  = prod_q;

    if (start) begin
      state_d = RX_LEN;
      len_d   = '0;
      n_d     = '0;
      cnt_d   = '0;
      a_d     = '0;
      b_d     = '0;
      acc_d   = '0;
      prod_d  = '0;
    end else begin
      unique case (state_q)
        RX_LEN: begin
          len_d = len_full;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(LEN_W - 1)) begin
            cnt_d = '0;
            if (len_full > LEN_W'(MAX_W))
              n_d = CW'(MAX_W);
            else
              n_d = len_full[CW-1:0];
            state_d = (n_d == '0) ? FIN : RX_A;
          end
        end
        RX_A: begin
`ifdef MULT_SIGNED_EN
          // every bit from here up takes this value: sign extension
          for (int i = 0; i < PROD_W; i++)
            if (i >= int'(cnt_q)) a_d[i] = in;
`else
          a_d[cnt_q] = in;
`endif
          cnt_d = cnt_q + CW'(1);
          if (last) begin
            cnt_d   = '0;
            state_d = RX_B;
          end
        end
        RX_B: begin
`ifdef MULT_SIGNED_EN
          for (int i = 0; i < MAX_W; i++)
            if (i >= int'(cnt_q)) b_d[i] = in;
`else
          b_d[cnt_q[CW-2:0]] = in;
`endif
          cnt_d = cnt_q + CW'(1);
          if (last) begin
            cnt_d   = '0;
            state_d = CALC;
          end
        end
        CALC: begin
          if (b_q[0]) begin
`ifdef MULT_SIGNED_EN
            // multiplier sign bit carries negative weight
            acc_d = last ? acc_q - a_q : acc_q + a_q;
`else
            acc_d = acc_q + a_q;
`endif
          end
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
          cnt_d = cnt_q + CW'(1);
          if (last) begin
            cnt_d   = '0;
            state_d = FIN;
          end
        end
        FIN: begin
          prod_d  = {1'b1, acc_q};
          state_d = DONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mult.sv
// Directed bench for serial_mult: frames, clamp, N=0, reset, restart.
module tb_serial_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_b;
  logic        ctrl;
  logic [32:0] prod;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  serial_mult dut (
    .clk  (clk),
    .rst  (rst),
    .in   (in_b),
    .ctrl (ctrl),
    .prod (prod)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [32:0] obs,
                     input logic [32:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start;
    ctrl = 1'b0;
    tick;
    ctrl = 1'b1;
    tick;
  endtask

  task automatic send(input logic [15:0] v, input int nb);
    for (int i = 0; i < nb; i++) begin
      in_b = v[i];
      tick;
    end
  endtask

  task automatic frame(input string tag, input logic [7:0] len,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp);
    int n;
    n = (len > 8'd16) ? 16 : int'(len);
    start;
    chk({tag, "_clr"}, prod, 33'h0);
    send(16'(len), 8);
    send(a, n);
    send(b, n);
    for (int i = 0; i < n; i++) begin
      in_b = 1'($urandom);
      tick;
    end
    chk({tag, "_busy"}, prod, 33'h0);
    in_b = 1'b1;
    tick;
    chk(tag, prod, {1'b1, exp});
  endtask

  logic [31:0] e_ff, e_sgn, e_rst2;

  initial begin
`ifdef MULT_SIGNED_EN
    e_ff   = 32'h0000_0001;
    e_sgn  = 32'hFFFF_FFFD;
    e_rst2 = 32'h0000_0002;
`else
    e_ff   = 32'hFFFE_0001;
    e_sgn  = 32'h0000_002D;
    e_rst2 = 32'h0000_0006;
`endif
    rst  = 1'b0;
    ctrl = 1'b0;
    in_b = 1'b0;
    tick;
    tick;
    chk("reset", prod, 33'h0);
    rst = 1'b1;
    tick;

    frame("n10", 8'd10, 16'd555, 16'd170, 32'd94350);
    ctrl = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_b = 1'($urandom);
      tick;
    end
    chk("hold", prod, {1'b1, 32'd94350});

    frame("n16", 8'd16, 16'hFFFF, 16'hFFFF, e_ff);
    frame("clamp", 8'd200, 16'h1234, 16'h0002, 32'h2468);
    frame("n0", 8'd0, 16'h0, 16'h0, 32'h0);
    in_b = 1'b1;
    tick;
    tick;
    chk("n0_hold", prod, 33'h1_0000_0000);

    frame("sgn", 8'd4, 16'hF, 16'h3, e_sgn);

    rst = 1'b0;
    #2;
    chk("rst_done", prod, 33'h0);
    rst = 1'b1;
    tick;
    start;
    send(16'd4, 8);
    send(16'd3, 2);
    rst = 1'b0;
    ctrl = 1'b0;
    #2;
    chk("rst_rxa", prod, 33'h0);
    tick;
    chk("rst_hold", prod, 33'h0);
    rst = 1'b1;
    tick;
    frame("after_rst", 8'd4, 16'd3, 16'd5, 32'hF);

    start;
    send(16'd10, 8);
    send(16'd555, 10);
    send(16'd170, 10);
    tick;
    tick;
    tick;
    frame("restart", 8'd2, 16'd2, 16'd3, e_rst2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
